// File: rtl/tri_regs_scan_ctl.sv
// tri_regs_scan_ctl: sequencer for scan-only configuration latch rings.
// Accepts a shift request and drives the selected ring's thold_b/force
// controls and serial scan-in for exactly len cycles. It captures the ring's
// scan-out bits and returns them through a response handshake.
// Optional build feature: define TRI_REGS_SCAN_CTL_PARITY_EN to add the
// req_par input. This is even parity over req_wdata[len-1:0], and a request
// with a parity mismatch is rejected without any shifting.
module tri_regs_scan_ctl #(
  parameter int NRINGS = 4,
  parameter int RSEL_W = 2,
  parameter int MAXLEN = 64,
  parameter int CNT_W  = 7
) (
  input  logic              nclk,
  input  logic              rst_b,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [RSEL_W-1:0] req_ring,
  input  logic [CNT_W-1:0]  req_len,
  input  logic [MAXLEN-1:0] req_wdata,
`ifdef TRI_REGS_SCAN_CTL_PARITY_EN
  input  logic              req_par,
`endif
  output logic              rsp_val,
  input  logic              rsp_rdy,
  output logic [MAXLEN-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [NRINGS-1:0] ring_force,
  output logic [NRINGS-1:0] ring_thold_b,
  output logic              ring_scin,
  input  logic [NRINGS-1:0] ring_scout
);

  localparam int IDX_W = $clog2(MAXLEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DRAIN,
    ST_RESP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_len;
  logic [RSEL_W-1:0]   r_ring;
  logic [MAXLEN-1:0]   r_wdata;
  logic [MAXLEN-1:0]   r_rdata;
  logic [NRINGS-1:0]   r_force;
  logic [NRINGS-1:0]   r_thold;
  logic                r_scin;
  logic                r_err;

  logic                w_accept;
  logic                w_bad_len;
  logic                w_bad_ring;
  logic                w_bad_par;
  logic                w_reject;
  logic                w_last;
  logic [IDX_W-1:0]    w_idx;
  logic [NRINGS-1:0]   w_req_oh;
  logic [NRINGS-1:0]   w_sel_oh;
  logic [RSEL_W:0]     w_ring_ext;

`ifdef TRI_REGS_SCAN_CTL_PARITY_EN
  // Even parity over the low len bits of the scan-in data.
  function automatic logic f_par(input logic [MAXLEN-1:0] d,
                                 input logic [CNT_W-1:0]  len);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAXLEN; i++) begin
      if (i < int'(len)) p = p ^ d[i];
    end
    return p;
  endfunction

  assign w_bad_par = (f_par(req_wdata, req_len) != req_par);
`else
  assign w_bad_par = 1'b0;
`endif

  assign w_accept   = (r_state == ST_IDLE) && req_val;
  assign w_ring_ext = {1'b0, req_ring};
  assign w_bad_len  = (req_len == '0) || (req_len > CNT_W'(MAXLEN));
  assign w_bad_ring = (w_ring_ext >= (RSEL_W+1)'(NRINGS));
  assign w_reject   = w_bad_len || w_bad_ring || w_bad_par;
  assign w_req_oh   = NRINGS'(1) << req_ring;
  assign w_sel_oh   = NRINGS'(1) << r_ring;
  assign w_last     = (r_cnt == (r_len - CNT_W'(1)));
  assign w_idx      = r_cnt[IDX_W-1:0];

  assign req_rdy      = (r_state == ST_IDLE);
  assign rsp_val      = (r_state == ST_RESP);
  assign busy         = (r_state != ST_IDLE);
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;
  assign ring_force   = r_force;
  assign ring_thold_b = r_thold;
  assign ring_scin    = r_scin;

  // Request capture; the scan-in word shifts right so bit 0 always holds the next bit to send.
  always_ff @(posedge nclk) begin
    if (w_accept) begin
      r_ring  <= req_ring;
      r_len   <= req_len;
      r_wdata <= req_wdata;
    end else if ((r_state == ST_SETUP) || (r_state == ST_SHIFT)) begin
      r_wdata <= r_wdata >> 1;
    end
  end

  // Sequencer: ring controls are registered and set one edge ahead of the state they belong to.
  always_ff @(posedge nclk) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_force <= '0;
      r_thold <= '0;
      r_scin  <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_val) begin
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= w_reject;
            if (w_reject) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_SETUP;
              r_thold <= w_req_oh;
            end
          end
        end
        ST_SETUP: begin
          r_cnt   <= '0;
          r_force <= w_sel_oh;
          r_thold <= w_sel_oh;
          r_scin  <= r_wdata[0];
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_rdata[w_idx] <= ring_scout[r_ring];
          r_cnt          <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_force <= '0;
            r_thold <= '0;
            r_scin  <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_scin  <= r_wdata[0];
          end
        end
        ST_DRAIN: begin
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_rdy) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_force <= '0;
          r_thold <= '0;
          r_scin  <= 1'b0;
        end
      endcase
    end
  end

endmodule
